// File: rtl/game_controller.sv
// Whack-a-mole round sequencer: spawns moles, times the hit window, tracks lives and rounds.
// Optional streak/bonus tracking is built when GAME_CTRL_STREAK_EN is defined.
module game_controller #(
  parameter int unsigned LIVES  = 3,
  parameter int unsigned ROUNDS = 20,
  parameter int unsigned GAP_MS = 250
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_pulse,
  input  logic [1:0] level,
  input  logic       tick_1ms,
  input  logic       hit_pulse,
  input  logic       miss_pulse,
  output logic       mole_spawn,
  output logic       mole_clear,
  output logic       round_active,
  output logic [3:0] lives_left,
  output logic [7:0] round_num,
  output logic       game_over,
  output logic       game_won,
  output logic [3:0] streak,
  output logic       bonus_pulse
);

  localparam int unsigned WIN_W  = 11;
  localparam int unsigned GAP_W  = 16;
  localparam int unsigned LIFE_W = 4;
  localparam int unsigned RND_W  = 8;

  typedef enum logic [2:0] {
    S_IDLE, S_SPAWN, S_WAIT, S_HIT, S_MISS, S_GAP, S_DONE
  } state_t;

  state_t             state, state_next;
  logic               start_game;
  logic [WIN_W-1:0]   win_len, win_sel, win_cnt;
  logic [GAP_W-1:0]   gap_cnt;

  // Window length for the requested difficulty
  always_comb begin
    win_sel = WIN_W'(1500);
    case (level)
      2'b01:   win_sel = WIN_W'(1000);
      2'b10:   win_sel = WIN_W'(750);
      default: win_sel = WIN_W'(1500);
    endcase
  end

  // Next-state logic; hit beats miss beats timeout
  always_comb begin
    state_next = state;
    start_game = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (start_pulse) begin
          state_next = S_SPAWN;
          start_game = 1'b1;
        end
      end
      S_SPAWN: state_next = S_WAIT;
      S_WAIT: begin
        if (hit_pulse)
          state_next = S_HIT;
        else if (miss_pulse)
          state_next = S_MISS;
        else if (tick_1ms && (win_cnt + WIN_W'(1)) == win_len)
          state_next = S_MISS;
      end
      S_HIT: begin
        if (round_num == RND_W'(ROUNDS))
          state_next = S_DONE;
        else
          state_next = S_GAP;
      end
      S_MISS: begin
        if (lives_left == LIFE_W'(0) || round_num == RND_W'(ROUNDS))
          state_next = S_DONE;
        else
          state_next = S_GAP;
      end
      S_GAP: begin
        if (tick_1ms && (gap_cnt + GAP_W'(1)) == GAP_W'(GAP_MS))
          state_next = S_SPAWN;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // State, counters and registered outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= S_IDLE;
      win_len      <= '0;
      win_cnt      <= '0;
      gap_cnt      <= '0;
      lives_left   <= LIFE_W'(LIVES);
      round_num    <= '0;
      mole_spawn   <= 1'b0;
      mole_clear   <= 1'b0;
      round_active <= 1'b0;
      game_over    <= 1'b0;
      game_won     <= 1'b0;
    end else begin
      state <= state_next;

      if (start_game) begin
        win_len    <= win_sel;
        lives_left <= LIFE_W'(LIVES);
        round_num  <= '0;
      end

      if (state == S_SPAWN)
        win_cnt <= '0;
      else if (state == S_WAIT && tick_1ms)
        win_cnt <= win_cnt + WIN_W'(1);

      if (state != S_GAP)
        gap_cnt <= '0;
      else if (tick_1ms)
        gap_cnt <= gap_cnt + GAP_W'(1);

      // Round bookkeeping lands with the HIT/MISS state so its exit decision sees it
      if (state_next == S_HIT || state_next == S_MISS)
        round_num <= round_num + RND_W'(1);
      if (state_next == S_MISS)
        lives_left <= lives_left - LIFE_W'(1);

      mole_spawn   <= (state_next == S_SPAWN);
      mole_clear   <= (state_next == S_HIT) || (state_next == S_MISS);
      round_active <= (state_next == S_WAIT);
      game_over    <= (state_next == S_DONE);
      game_won     <= (state_next == S_DONE) && (lives_left != LIFE_W'(0));
    end
  end

`ifdef GAME_CTRL_STREAK_EN
  logic [3:0] streak_inc;

  assign streak_inc = (streak == 4'd15) ? 4'd15 : streak + 4'd1;

  // Consecutive-hit counter with a bonus every fourth hit
  always_ff @(posedge clk) begin
    if (!rst) begin
      streak      <= '0;
      bonus_pulse <= 1'b0;
    end else begin
      bonus_pulse <= 1'b0;
      if (start_game) begin
        streak <= '0;
      end else if (state_next == S_HIT) begin
        streak      <= streak_inc;
        bonus_pulse <= (streak_inc[1:0] == 2'b00);
      end else if (state_next == S_MISS) begin
        streak <= '0;
      end
    end
  end
`else
  assign streak      = '0;
  assign bonus_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_game_controller.sv
// Randomized game sessions against a round-level reference model of the mole controller.
module tb_game_controller;

  localparam int unsigned LIVES  = 3;
  localparam int unsigned ROUNDS = 10;
  localparam int unsigned GAP_MS = 5;
`ifdef GAME_CTRL_STREAK_EN
  localparam bit STREAK_EN = 1'b1;
`else
  localparam bit STREAK_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, start_pulse, tick_1ms, hit_pulse, miss_pulse;
  logic [1:0] level;
  logic       mole_spawn, mole_clear, round_active, game_over, game_won, bonus_pulse;
  logic [3:0] lives_left, streak;
  logic [7:0] round_num;

  game_controller #(.LIVES(LIVES), .ROUNDS(ROUNDS), .GAP_MS(GAP_MS)) dut (
    .clk(clk), .rst(rst), .start_pulse(start_pulse), .level(level),
    .tick_1ms(tick_1ms), .hit_pulse(hit_pulse), .miss_pulse(miss_pulse),
    .mole_spawn(mole_spawn), .mole_clear(mole_clear), .round_active(round_active),
    .lives_left(lives_left), .round_num(round_num), .game_over(game_over),
    .game_won(game_won), .streak(streak), .bonus_pulse(bonus_pulse)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int spawn_cnt, clear_cnt;

  // Reference model: game-level quantities only
  int win_tab [4] = '{1500, 1000, 750, 1500};
  int m_lives, m_rounds, m_streak, m_win;
  bit m_done, m_bonus;

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    chk("spawn_clear_overlap", int'(mole_spawn & mole_clear), 0);
    spawn_cnt += int'(mole_spawn);
    clear_cnt += int'(mole_clear);
  endtask

  task automatic begin_game(input logic [1:0] lvl);
    level = lvl;
    start_pulse = 1'b1;
    spawn_cnt = 0;
    clear_cnt = 0;
    cyc();
    start_pulse = 1'b0;
    m_lives = LIVES; m_rounds = 0; m_streak = 0; m_done = 0;
    m_win = win_tab[lvl];
    chk("start_spawn", int'(mole_spawn), 1);
    chk("start_lives", int'(lives_left), LIVES);
    chk("start_round", int'(round_num), 0);
    chk("start_streak", int'(streak), 0);
    chk("start_over", int'(game_over), 0);
    cyc();
    chk("wait_active", int'(round_active), 1);
  endtask

  // kind: 0 timeout, 1 hit, 2 miss, 3 hit+miss together; d = tick carrying the pulse
  task automatic play_round(input int kind, input int d, input logic [1:0] lvl_mid);
    int  end_tick = 0;
    int  exp_end;
    bit  is_hit;
    if (kind != 0 && d <= m_win) begin
      exp_end = d;
      is_hit  = (kind != 2);
    end else begin
      exp_end = m_win;
      is_hit  = 1'b0;
    end
    for (int i = 1; i <= m_win + 2 && end_tick == 0; i++) begin
      tick_1ms   = 1'b1;
      hit_pulse  = (kind == 1 || kind == 3) && (i == d);
      miss_pulse = (kind == 2 || kind == 3) && (i == d);
      if (i == 2) level = lvl_mid;
      cyc();
      tick_1ms = 1'b0; hit_pulse = 1'b0; miss_pulse = 1'b0;
      if (mole_clear) begin
        end_tick = i;
      end else begin
        start_pulse = ($urandom_range(0, 7) == 0);
        cyc();
        start_pulse = 1'b0;
        chk("wait_active", int'(round_active), 1);
      end
    end
    if (end_tick == 0) begin
      chk("round_end_seen", 0, 1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $fatal(1, "FAIL round never ended");
    end
    chk("end_tick", end_tick, exp_end);

    m_rounds++;
    if (is_hit) begin
      m_streak = (m_streak < 15) ? m_streak + 1 : 15;
      m_bonus  = (m_streak % 4 == 0);
    end else begin
      m_lives--;
      m_streak = 0;
      m_bonus  = 1'b0;
    end
    m_done = (m_lives == 0) || (m_rounds == ROUNDS);

    chk("end_round", int'(round_num), m_rounds);
    chk("end_lives", int'(lives_left), m_lives);
    chk("end_streak", int'(streak), STREAK_EN ? m_streak : 0);
    chk("end_bonus", int'(bonus_pulse), STREAK_EN ? int'(m_bonus) : 0);
    chk("end_active", int'(round_active), 0);

    hit_pulse = 1'($urandom_range(0, 1));
    cyc();
    hit_pulse = 1'b0;
    chk("post_clear", int'(mole_clear), 0);
    chk("post_bonus", int'(bonus_pulse), 0);
    if (m_done) begin
      chk("done_over", int'(game_over), 1);
      chk("done_won", int'(game_won), int'(m_lives > 0));
      chk("done_round", int'(round_num), m_rounds);
      chk("done_lives", int'(lives_left), m_lives);
      hit_pulse = 1'b1; cyc(); hit_pulse = 1'b0;
      miss_pulse = 1'b1; cyc(); miss_pulse = 1'b0;
      chk("done_hold_over", int'(game_over), 1);
      chk("done_hold_lives", int'(lives_left), m_lives);
      chk("done_hold_round", int'(round_num), m_rounds);
      chk("done_no_spawn", int'(mole_spawn), 0);
    end else begin
      chk("gap_over", int'(game_over), 0);
      chk("gap_active", int'(round_active), 0);
      for (int g = 1; g <= int'(GAP_MS); g++) begin
        tick_1ms    = 1'b1;
        miss_pulse  = 1'($urandom_range(0, 1));
        start_pulse = 1'($urandom_range(0, 1));
        cyc();
        tick_1ms = 1'b0; miss_pulse = 1'b0; start_pulse = 1'b0;
        chk("gap_spawn", int'(mole_spawn), int'(g == int'(GAP_MS)));
        if (g < int'(GAP_MS)) cyc();
      end
      chk("gap_lives", int'(lives_left), m_lives);
      cyc();
      chk("respawn_active", int'(round_active), 1);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; start_pulse = 1'b0; level = 2'b00;
    tick_1ms = 1'b0; hit_pulse = 1'b0; miss_pulse = 1'b0;
    spawn_cnt = 0; clear_cnt = 0;
    cyc();
    start_pulse = 1'b1;
    cyc();
    start_pulse = 1'b0;
    chk("rst_lives", int'(lives_left), LIVES);
    chk("rst_round", int'(round_num), 0);
    chk("rst_streak", int'(streak), 0);
    chk("rst_spawn", int'(mole_spawn), 0);
    chk("rst_clear", int'(mole_clear), 0);
    chk("rst_active", int'(round_active), 0);
    chk("rst_over", int'(game_over), 0);
    chk("rst_won", int'(game_won), 0);
    chk("rst_bonus", int'(bonus_pulse), 0);
    rst = 1'b1;
    hit_pulse = 1'b1;
    cyc();
    hit_pulse = 1'b0;
    chk("idle_ignore_hit", int'(mole_clear), 0);
    chk("idle_no_spawn", int'(mole_spawn), 0);

    // Game over by three timeouts at level 01
    begin_game(2'b01);
    repeat (3) play_round(0, 0, 2'b01);

    // Priority and level latch at level 10
    begin_game(2'b10);
    play_round(1, 750, 2'b00);
    play_round(0, 0, 2'b00);
    play_round(3, 7, 2'b11);
    while (!m_done)
      play_round(($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 3)),
                 int'($urandom_range(1, 40)), 2'($urandom_range(0, 3)));

    // Winning game: every round hit
    begin_game(2'($urandom_range(0, 3)));
    for (int r = 0; r < int'(ROUNDS); r++)
      play_round(1, int'($urandom_range(1, 30)), 2'($urandom_range(0, 3)));
    chk("win_spawns", spawn_cnt, ROUNDS);
    chk("win_clears", clear_cnt, ROUNDS);
    chk("win_flag", int'(game_won), 1);

    // Random mixed game
    begin_game(2'b00);
    while (!m_done)
      play_round(($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 3)),
                 int'($urandom_range(1, 60)), 2'($urandom_range(0, 3)));

    // Reset mid-window at tick 500
    begin_game(2'b01);
    for (int i = 0; i < 500; i++) begin
      tick_1ms = 1'b1; cyc(); tick_1ms = 1'b0; cyc();
    end
    chk("pre_rst_active", int'(round_active), 1);
    rst = 1'b0;
    start_pulse = 1'b1;
    cyc();
    start_pulse = 1'b0;
    rst = 1'b1;
    chk("midrst_active", int'(round_active), 0);
    chk("midrst_lives", int'(lives_left), LIVES);
    chk("midrst_round", int'(round_num), 0);
    chk("midrst_clear", int'(mole_clear), 0);
    chk("midrst_spawn", int'(mole_spawn), 0);
    cyc();
    chk("postrst_clear", int'(mole_clear), 0);
    chk("postrst_spawn", int'(mole_spawn), 0);
    chk("postrst_over", int'(game_over), 0);
    begin_game(2'b10);
    play_round(1, 3, 2'b10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/game_controller.md
GAME_CONTROLLER -- requirements
Module: game_controller

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- LIVES, 3, misses allowed before game over (1-15).
- ROUNDS, 20, mole rounds per game (1-255).
- GAP_MS, 250, dark interval between rounds in ms ticks (1-65535).
REQ-002 Ports (name, direction, width, meaning), one per line; clock and reset first:
- clk, in, 1, system clock; all logic on rising edge.
- rst, in, 1, reset; synchronous, active-low.
- start_pulse, in, 1, one-cycle request to begin a game.
- level, in, 2, difficulty select; sampled on game start only.
- tick_1ms, in, 1, one-cycle pulse every 1 ms.
- hit_pulse, in, 1, one-cycle pulse: lit mole was hit.
- miss_pulse, in, 1, one-cycle pulse: wrong switch pressed.
- mole_spawn, out, 1, one-cycle pulse commanding the LED block to light a new random mole.
- mole_clear, out, 1, one-cycle pulse commanding all moles off.
- round_active, out, 1, high while a mole window is open.
- lives_left, out, 4, remaining lives.
- round_num, out, 8, rounds completed this game.
- game_over, out, 1, high in DONE state.
- game_won, out, 1, high in DONE when all rounds completed with lives > 0.
- streak, out, 4, consecutive-hit count (see REQ-024).
- bonus_pulse, out, 1, one-cycle streak bonus pulse (see REQ-024).

Function
REQ-003 States SHALL be IDLE, SPAWN, WAIT, HIT, MISS, GAP, DONE.
REQ-004 Window length SHALL be latched from level at IDLE->SPAWN: 00=1500, 01=1000, 10=750, 11=1500 ms; level changes mid-game have no effect.
REQ-005 IDLE: outputs idle; start_pulse -> SPAWN, lives_left=LIVES, round_num=0, streak=0.
REQ-006 SPAWN (1 cycle): assert mole_spawn, clear the window counter, -> WAIT.
REQ-007 WAIT: round_active=1; the window counter increments on each tick_1ms.
REQ-008 WAIT exits: hit_pulse -> HIT; else miss_pulse -> MISS; else the tick that makes the counter equal the window length -> MISS.
REQ-009 Priority within one cycle SHALL be hit > miss > timeout.
REQ-010 Hit/miss pulses outside WAIT SHALL be ignored.
REQ-011 HIT (1 cycle): mole_clear=1, round_num+1, streak+1 saturating at 15, -> GAP.
REQ-012 MISS (1 cycle): mole_clear=1, round_num+1, lives_left-1, streak=0; -> DONE if lives_left becomes 0, else -> GAP.
REQ-013 After HIT or MISS, if round_num reaches ROUNDS, the next state SHALL be DONE instead of GAP.
REQ-014 GAP: count GAP_MS ticks, then -> SPAWN; mole_clear is not re-asserted.
REQ-015 DONE: game_over=1; game_won=1 only if lives_left>0; outputs hold; start_pulse -> SPAWN with a fresh game per REQ-005.
REQ-016 start_pulse in SPAWN/WAIT/HIT/MISS/GAP SHALL be ignored.
REQ-017 Hit-to-mole_clear latency SHALL be 1 cycle; timeout-to-mole_clear latency SHALL be 1 cycle after the terminating tick.
REQ-018 Window counter: 11 bits; gap counter: 16 bits; neither wraps (cleared on state entry).
REQ-019 mole_spawn and mole_clear SHALL never assert in the same cycle.

Reset
REQ-020 With rst=0 at a clk edge, the block SHALL enter IDLE.
REQ-021 Reset values: lives_left=LIVES, round_num=0, streak=0; all other outputs 0.
REQ-022 Reset mid-game SHALL abort without emitting mole_clear; the LED block is reset by the same signal.
REQ-023 Reset SHALL take priority over all inputs in the same cycle.

Configuration
REQ-024 Macro GAME_CTRL_STREAK_EN:
- Defined: in HIT, if the incremented streak is a nonzero multiple of 4, assert bonus_pulse for that cycle; streak output is live.
- Undefined: streak tied to 0, bonus_pulse tied to 0, streak register removed; all other behaviour identical.

Verification
REQ-025 Game over: LIVES=3, ROUNDS=20; start at level 01, no hits -> after each 1000 ticks MISS; lives_left steps 3,2,1,0; game_over=1, game_won=0, round_num=3.
REQ-026 Win: ROUNDS=4; hit_pulse 10 ticks into every WAIT -> round_num=4, lives_left=3, game_won=1; mole_spawn 4 times, mole_clear 4 times.
REQ-027 Priority: hit_pulse and the 750th tick together (level 10) -> HIT, lives unchanged; hit_pulse and miss_pulse together -> HIT.
REQ-028 Level latch: start at level 10, switch to 00 during WAIT -> the timeout still occurs at tick 750 on this and later rounds.
REQ-029 Streak (macro defined): 8 consecutive hits -> bonus_pulse after hits 4 and 8; a miss resets streak to 0. Macro undefined -> bonus_pulse stays 0.
REQ-030 Reset in WAIT at tick 500 -> next cycle IDLE, round_active=0, lives_left=3, no mole_clear pulse.
